mmio_responder: RTL

MMIO_RESPONDER -- requirements
Module: mmio_responder

---
 rtl/mmio_responder.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mmio_responder.sv
// Memory-mapped UART/counter responder sitting beside the data BRAM; loads answer one cycle later.
// Optional macro MMIO_RX_FIFO_EN selects an RX_DEPTH-entry RX FIFO instead of a single-byte holding register.
module mmio_responder #(
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_en,
  input  logic        dmem_write,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wbe,
  input  logic        inst_retire,
  output logic [31:0] mmio_rdata,
  output logic        mmio_sel,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  if (TX_DEPTH < 2 || TX_DEPTH > 64 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_tx
    $error("mmio_responder: TX_DEPTH must be a power of two in 2..64");
  end
  if (RX_DEPTH < 2 || RX_DEPTH > 64 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_rx
    $error("mmio_responder: RX_DEPTH must be a power of two in 2..64");
  end

  localparam int unsigned   TXAW   = $clog2(TX_DEPTH);
  localparam logic [TXAW:0] TX_CAP = TX_DEPTH[TXAW:0];

  localparam logic [27:0] OFF_STATUS = 28'h000_0000;
  localparam logic [27:0] OFF_RXDATA = 28'h000_0004;
  localparam logic [27:0] OFF_TXDATA = 28'h000_0008;
  localparam logic [27:0] OFF_CYCLES = 28'h000_0010;
  localparam logic [27:0] OFF_INSTS  = 28'h000_0014;
  localparam logic [27:0] OFF_CLEAR  = 28'h000_0018;

  logic        hit, ld, st;
  logic [27:0] off;
  logic        tx_push_req, tx_push, tx_pop, tx_ready;
  logic        rx_push, rx_pop, rx_nonempty, rx_full;
  logic [7:0]  rx_head;
  logic        cnt_clr;
  logic        tx_overflow;
  logic [31:0] cyc_cnt, inst_cnt;
  logic [31:0] rd_next;
  logic        unused_ok;

  assign unused_ok = ^{dmem_wdata[31:8], dmem_wbe[3:1]};

  assign hit = dmem_en && (dmem_addr[31:28] == 4'h8);
  assign ld  = hit && !dmem_write;
  assign st  = hit &&  dmem_write;
  assign off = dmem_addr[27:0];

  assign cnt_clr     = st && (off == OFF_CLEAR);
  assign tx_push_req = st && (off == OFF_TXDATA) && dmem_wbe[0];
  assign rx_pop      = ld && (off == OFF_RXDATA) && rx_nonempty;

  // TX FIFO
  logic [7:0]      tx_mem [TX_DEPTH];
  logic [TXAW-1:0] tx_wptr, tx_rptr;
  logic [TXAW:0]   tx_count;

  // Acceptance uses the count before any same-cycle pop, so a full FIFO drops the store.
  assign tx_ready      = (tx_count < TX_CAP);
  assign tx_push       = tx_push_req && tx_ready;
  assign uart_tx_valid = (tx_count != '0);
  assign uart_tx_data  = tx_mem[tx_rptr];
  assign tx_pop        = uart_tx_valid && uart_tx_ready;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= dmem_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr     <= '0;
      tx_rptr     <= '0;
      tx_count    <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
      if (cnt_clr)
        tx_overflow <= 1'b0;
      else if (tx_push_req && !tx_ready)
        tx_overflow <= 1'b1;
    end
  end

  // RX buffer
  assign rx_push       = uart_rx_valid && uart_rx_ready;
  assign uart_rx_ready = rst_n && !rx_full;

`ifdef MMIO_RX_FIFO_EN
  localparam int unsigned   RXAW   = $clog2(RX_DEPTH);
  localparam logic [RXAW:0] RX_CAP = RX_DEPTH[RXAW:0];

  logic [7:0]      rx_mem [RX_DEPTH];
  logic [RXAW-1:0] rx_wptr, rx_rptr;
  logic [RXAW:0]   rx_count;

  assign rx_nonempty = (rx_count != '0);
  assign rx_full     = (rx_count == RX_CAP);
  assign rx_head     = rx_mem[rx_rptr];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= uart_rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end
`else
  logic [7:0] rx_hold;
  logic       rx_hold_v;

  assign rx_nonempty = rx_hold_v;
  assign rx_full     = rx_hold_v;
  assign rx_head     = rx_hold;

  // Push is only possible when empty and pop only when full, so they never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_hold   <= '0;
      rx_hold_v <= 1'b0;
    end else if (rx_push) begin
      rx_hold   <= uart_rx_data;
      rx_hold_v <= 1'b1;
    end else if (rx_pop) begin
      rx_hold_v <= 1'b0;
    end
  end
`endif

  // Free-running counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else if (cnt_clr) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (inst_retire) inst_cnt <= inst_cnt + 32'd1;
    end
  end

  // Load read mux
  always_comb begin
    rd_next = '0;
    if (ld) begin
      case (off)
        OFF_STATUS: rd_next = {29'b0, tx_overflow, rx_nonempty, tx_ready};
        OFF_RXDATA: rd_next = {24'b0, rx_nonempty ? rx_head : 8'h00};
        OFF_CYCLES: rd_next = cyc_cnt;
        OFF_INSTS:  rd_next = inst_cnt;
        default:    rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmio_rdata <= '0;
      mmio_sel   <= 1'b0;
    end else begin
      mmio_rdata <= rd_next;
      mmio_sel   <= ld;
    end
  end

endmodule
